// File: rtl/io_filter_cfg_if.sv
// CPU/memory-side port bus of the IO filter: per-port strobes and flat data words,
// port p occupying bits [p*DATA_WIDTH +: DATA_WIDTH].
interface io_filter_cfg_if #(
  parameter int IO_PINS    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int NP = IO_PINS + 2;

  logic [NP-1:0]            port_active_in;
  logic [NP-1:0]            port_active_out;
  logic [NP*DATA_WIDTH-1:0] port_data_in;
  logic [NP*DATA_WIDTH-1:0] port_data_out;

  modport master (
    input  port_active_in, port_data_in,
    output port_active_out, port_data_out
  );

  modport slave (
    output port_active_in, port_data_in,
    input  port_active_out, port_data_out
  );
endinterface

// File: rtl/io_filter_cfg.sv
// Programmable pin/port IO filter: per-pin mode (level, output, edge, debounced),
// 2-flop input synchronisers, and an aggregated event-status port.
module io_filter_cfg_pin #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_pin,
  input  logic       i_cfg_we,
  input  logic [1:0] i_cfg_mode,
  input  logic       i_wr_en,
  input  logic       i_wr_bit,
  output logic       o_dir,
  output logic       o_pin_out,
  output logic       o_act,
  output logic       o_evt,
  output logic [1:0] o_dat
);
  typedef enum logic [1:0] {
    M_LEVEL = 2'b00,
    M_OUT   = 2'b01,
    M_EDGE  = 2'b10,
    M_DEB   = 2'b11
  } mode_t;

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  mode_t         r_mode;
  logic          r_dir, r_pout, r_act, r_evt;
  logic [1:0]    r_dat;
  logic          r_sync1, r_sync2, r_stable;
  logic [CW-1:0] r_cnt;
  mode_t         w_new_mode;

  assign w_new_mode = mode_t'(i_cfg_mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode   <= M_LEVEL;
      r_dir    <= 1'b0;
      r_pout   <= 1'b0;
      r_act    <= 1'b0;
      r_evt    <= 1'b0;
      r_dat    <= 2'b00;
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_pin;
      r_sync2 <= r_sync1;
      r_evt   <= 1'b0;

      // Data writes see the mode held before any same-cycle config write.
      if (i_wr_en && r_mode == M_OUT) r_pout <= i_wr_bit;

      case (r_mode)
        M_LEVEL: begin
          r_act <= 1'b1;
          r_dat <= {1'b0, r_sync2};
        end
        M_OUT: begin
          r_act <= 1'b0;
          r_dat <= 2'b00;
        end
        M_EDGE: begin
          r_act <= 1'b0;
          r_dat <= 2'b00;
          if (r_sync2 != r_stable) begin
            r_stable <= r_sync2;
            r_act    <= 1'b1;
            r_evt    <= 1'b1;
            r_dat    <= {r_sync2, r_sync2};
          end
        end
        M_DEB: begin
          r_act <= 1'b0;
          r_dat <= 2'b00;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
            r_act    <= 1'b1;
            r_evt    <= 1'b1;
            r_dat    <= {r_sync2, r_sync2};
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      // A mode change re-baselines the pin so it never raises an event itself.
      if (i_cfg_we) begin
        r_mode   <= w_new_mode;
        r_dir    <= (w_new_mode == M_OUT);
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_evt    <= 1'b0;
        r_act    <= (w_new_mode == M_LEVEL);
        r_dat    <= (w_new_mode == M_LEVEL) ? {1'b0, r_sync2} : 2'b00;
        if (w_new_mode != M_OUT) r_pout <= 1'b0;
      end
    end
  end

  assign o_dir     = r_dir;
  assign o_pin_out = r_pout;
  assign o_act     = r_act;
  assign o_evt     = r_evt;
  assign o_dat     = r_dat;
endmodule

module io_filter_cfg #(
  parameter int IO_PINS         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IO_PINS-1:0] pin_dir,
  input  logic [IO_PINS-1:0] pin_data_in,
  output logic [IO_PINS-1:0] pin_data_out,
  io_filter_cfg_if.slave     bus
);
  localparam int NP = IO_PINS + 2;
  localparam int IW = DATA_WIDTH - 2;

  logic                      w_cfg_we;
  logic [DATA_WIDTH-1:0]     w_cfg_word;
  logic [IW-1:0]             w_cfg_idx;
  logic [IO_PINS-1:0]        w_act, w_evt;
  logic [IO_PINS-1:0][1:0]   w_dat;
  logic                      w_unused;

  assign w_cfg_we   = bus.port_active_out[IO_PINS];
  assign w_cfg_word = bus.port_data_out[IO_PINS*DATA_WIDTH +: DATA_WIDTH];
  assign w_cfg_idx  = w_cfg_word[DATA_WIDTH-1:2];

  // Status-port writes and the upper bits of pin-port writes carry no meaning.
  assign w_unused = ^{bus.port_data_out, bus.port_active_out[NP-1]};

  genvar p;
  generate
    for (p = 0; p < IO_PINS; p++) begin : g_pin
      io_filter_cfg_pin #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pin (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_pin      (pin_data_in[p]),
        .i_cfg_we   (w_cfg_we && (w_cfg_idx == IW'(p))),
        .i_cfg_mode (w_cfg_word[1:0]),
        .i_wr_en    (bus.port_active_out[p]),
        .i_wr_bit   (bus.port_data_out[p*DATA_WIDTH]),
        .o_dir      (pin_dir[p]),
        .o_pin_out  (pin_data_out[p]),
        .o_act      (w_act[p]),
        .o_evt      (w_evt[p]),
        .o_dat      (w_dat[p])
      );
    end
  endgenerate

  always_comb begin
    bus.port_active_in = '0;
    bus.port_data_in   = '0;
    bus.port_active_in[IO_PINS-1:0] = w_act;
    bus.port_active_in[NP-1]        = |w_evt;
    for (int i = 0; i < IO_PINS; i++) bus.port_data_in[i*DATA_WIDTH +: 2] = w_dat[i];
    bus.port_data_in[(NP-1)*DATA_WIDTH +: IO_PINS] = w_evt;
  end
endmodule

// File: tb/tb_io_filter_cfg.sv
// Directed bench for io_filter_cfg: reset, output/config vector table, then
// hand-written edge, simultaneous-event, debounce and async-reset sequences.
module tb_io_filter_cfg;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] pin_dir, pins, pin_data_out;

  io_filter_cfg_if #(.IO_PINS(4), .DATA_WIDTH(8)) bus ();

  io_filter_cfg #(.IO_PINS(4), .DATA_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pin_dir      (pin_dir),
    .pin_data_in  (pins),
    .pin_data_out (pin_data_out),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] aout;
    logic [7:0] cfg;
    logic [7:0] wdat;
    logic [3:0] e_dir;
    logic [3:0] e_pout;
    logic [5:0] e_act;
  } vec_t;

  vec_t vt[11];
  int n_tests = 0, n_fail = 0;
  int w_first, w_cnt;
  logic [7:0] w_stat, w_pdat;
  logic w_pact;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  task automatic cfg_wr(input logic [7:0] c);
    bus.port_active_out = 6'b010000;
    bus.port_data_out   = {8'h00, c, 32'h0};
    tick();
    bus.port_active_out = '0;
    bus.port_data_out   = '0;
  endtask

  // Drives p_hi, switches to p_lo after hi_cyc edges (0 = never), records status pulses.
  task automatic watch(input int pin, input int ncyc, input logic [3:0] p_hi,
                       input int hi_cyc, input logic [3:0] p_lo);
    pins = p_hi;
    w_first = 0; w_cnt = 0; w_stat = '0; w_pdat = '0; w_pact = 1'b0;
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      if (i == hi_cyc) pins = p_lo;
      if (bus.port_active_in[5]) begin
        w_cnt++;
        if (w_first == 0) begin
          w_first = i;
          w_stat  = bus.port_data_in[47:40];
          w_pdat  = bus.port_data_in[pin*8 +: 8];
          w_pact  = bus.port_active_in[pin];
        end
      end
    end
  endtask

  initial begin
    vt[0]  = '{6'b010000, 8'h05, 8'h00, 4'b0010, 4'b0000, 6'b001101};
    vt[1]  = '{6'b000010, 8'h00, 8'hFF, 4'b0010, 4'b0010, 6'b001101};
    vt[2]  = '{6'b000001, 8'h00, 8'hFF, 4'b0010, 4'b0010, 6'b001101};
    vt[3]  = '{6'b000010, 8'h00, 8'hFE, 4'b0010, 4'b0000, 6'b001101};
    vt[4]  = '{6'b000010, 8'h00, 8'h01, 4'b0010, 4'b0010, 6'b001101};
    vt[5]  = '{6'b010000, 8'h15, 8'h00, 4'b0010, 4'b0010, 6'b001101};
    vt[6]  = '{6'b010000, 8'h11, 8'h00, 4'b0010, 4'b0010, 6'b001101};
    vt[7]  = '{6'b010010, 8'h04, 8'h01, 4'b0000, 4'b0000, 6'b001111};
    vt[8]  = '{6'b010010, 8'h05, 8'h01, 4'b0010, 4'b0000, 6'b001101};
    vt[9]  = '{6'b000000, 8'h00, 8'h00, 4'b0010, 4'b0000, 6'b001101};
    vt[10] = '{6'b010000, 8'h04, 8'h00, 4'b0000, 4'b0000, 6'b001111};

    rst_n = 1'b0;
    pins  = 4'b0000;
    bus.port_active_out = '0;
    bus.port_data_out   = '0;

    for (int i = 0; i < 4; i++) begin
      pins = 4'(i * 5 + 3);
      tick();
      chk("reset_outputs", 64'({pin_dir, pin_data_out, bus.port_active_in, bus.port_data_in}), 64'h0);
    end

    pins  = 4'b0101;
    rst_n = 1'b1;
    tick();
    chk("level_act_after_reset", 64'(bus.port_active_in), 64'h0F);
    tick();
    chk("level_data_before_sync", 64'(bus.port_data_in), 64'h0);
    tick();
    chk("level_data_after_sync", 64'(bus.port_data_in), 64'h0000_0001_0001);

    foreach (vt[i]) begin
      bus.port_active_out = vt[i].aout;
      bus.port_data_out   = {8'h00, vt[i].cfg, vt[i].wdat, vt[i].wdat, vt[i].wdat, vt[i].wdat};
      tick();
      chk($sformatf("vec%0d_dir", i),  64'(pin_dir),            64'(vt[i].e_dir));
      chk($sformatf("vec%0d_pout", i), 64'(pin_data_out),       64'(vt[i].e_pout));
      chk($sformatf("vec%0d_act", i),  64'(bus.port_active_in), 64'(vt[i].e_act));
    end
    bus.port_active_out = '0;
    bus.port_data_out   = '0;

    // pin2 high in level mode, switched to edge: nothing fires
    cfg_wr(8'h0A);
    watch(2, 5, 4'b0101, 0, 4'b0101);
    chk("mode_switch_no_event", 64'(w_cnt), 64'd0);

    watch(2, 6, 4'b0001, 0, 4'b0001);
    chk("edge_fall_cnt",   64'(w_cnt),   64'd1);
    chk("edge_fall_lat",   64'(w_first), 64'd3);
    chk("edge_fall_stat",  64'(w_stat),  64'h04);
    chk("edge_fall_pdat",  64'(w_pdat),  64'h00);
    chk("edge_fall_pact",  64'(w_pact),  64'd1);

    watch(2, 6, 4'b0101, 0, 4'b0101);
    chk("edge_rise_cnt",   64'(w_cnt),   64'd1);
    chk("edge_rise_lat",   64'(w_first), 64'd3);
    chk("edge_rise_stat",  64'(w_stat),  64'h04);
    chk("edge_rise_pdat",  64'(w_pdat),  64'h03);
    chk("edge_rise_pact",  64'(w_pact),  64'd1);

    cfg_wr(8'h0E);
    watch(2, 6, 4'b0001, 0, 4'b0001);
    chk("pin2_fall_stat", 64'(w_stat), 64'h04);
    watch(3, 6, 4'b1101, 0, 4'b1101);
    chk("simul_cnt",  64'(w_cnt),  64'd1);
    chk("simul_stat", 64'(w_stat), 64'h0C);
    chk("simul_pdat", 64'(w_pdat), 64'h03);

    cfg_wr(8'h15);
    tick();
    chk("idx5_dir", 64'(pin_dir),            64'h0);
    chk("idx5_act", 64'(bus.port_active_in), 64'h03);

    cfg_wr(8'h03);
    watch(0, 8, 4'b1100, 0, 4'b1100);
    chk("deb_fall_cnt",  64'(w_cnt),   64'd1);
    chk("deb_fall_lat",  64'(w_first), 64'd6);
    chk("deb_fall_pdat", 64'(w_pdat),  64'h00);
    chk("deb_fall_stat", 64'(w_stat),  64'h01);

    watch(0, 12, 4'b1101, 3, 4'b1100);
    chk("deb_glitch_cnt", 64'(w_cnt), 64'd0);

    watch(0, 8, 4'b1101, 6, 4'b1100);
    chk("deb_rise_cnt",  64'(w_cnt),   64'd1);
    chk("deb_rise_lat",  64'(w_first), 64'd6);
    chk("deb_rise_pdat", 64'(w_pdat),  64'h03);
    chk("deb_rise_stat", 64'(w_stat),  64'h01);
    watch(0, 8, 4'b1100, 0, 4'b1100);
    chk("deb_back_cnt",  64'(w_cnt),  64'd1);
    chk("deb_back_pdat", 64'(w_pdat), 64'h00);

    cfg_wr(8'h05);
    bus.port_active_out = 6'b000010;
    bus.port_data_out   = 48'h0000_0101_0101;
    tick();
    bus.port_active_out = '0;
    bus.port_data_out   = '0;
    chk("pre_reset_pout", 64'(pin_data_out), 64'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_clear", 64'({pin_dir, pin_data_out, bus.port_active_in}), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_dir", 64'(pin_dir), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
